lbp_gray_host: RTL

//  Host-side end of the LBP gray/lbp memory interface: the responder that serves

---
 rtl/lbp_gray_if.sv | 42 ++++
 rtl/lbp_gray_host.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_gray_if.sv
// ----------------------------------------------------------------------------
// lbp_gray_if
//   Core-facing memory port of the LBP gray/lbp host. It bundles the read side
//   (gray image fetch) and the write side (LBP result store) used by the core.
//
//   Signals
//     gray_ready  host -> core  image is available, core may fetch
//     gray_req    core -> host  read request
//     gray_addr   core -> host  read address
//     gray_data   host -> core  read data, same cycle as gray_req
//     lbp_valid   core -> host  result write strobe
//     lbp_addr    core -> host  result address
//     lbp_data    core -> host  result code
//     finish      core -> host  core has completed the image
//
//   Modports
//     master  the LBP core (issues requests and writes)
//     slave   the host memory (responds and stores)
// ----------------------------------------------------------------------------
interface lbp_gray_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [DATA_W-1:0] gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [DATA_W-1:0] lbp_data;
    logic              finish;

    modport master (
        input  gray_ready, gray_data,
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );

    modport slave (
        output gray_ready, gray_data,
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );
endinterface : lbp_gray_if

// File: rtl/lbp_gray_host.sv
// ----------------------------------------------------------------------------
// lbp_gray_host
//   Host-side responder for the LBP core. Holds the gray image RAM that the
//   system loader fills and the core reads, captures LBP result writes into a
//   result RAM that the system reads back, and sequences one run:
//
//     IDLE --start--> SERVE --finish--> DRAIN --DRAIN_CYC cycles--> DONE
//                       |                                             ^
//                       +---- TIMEOUT_CYC cycles without finish ------+
//     DONE --start--> SERVE
//
//   Ports
//     clk            system clock, rising edge
//     reset          synchronous, active-high
//     load_en_i      gray RAM write strobe (honoured in IDLE/DONE only)
//     load_addr_i    gray RAM write address
//     load_data_i    gray RAM write data
//     start_i        one-cycle pulse, begins a run from IDLE/DONE
//     core_if        slave end of the core memory port (lbp_gray_if)
//     rd_addr_i      result RAM readback address
//     rd_data_o      result RAM readback data, one cycle latency
//     busy_o         run in progress (SERVE or DRAIN)
//     done_o         run complete, level while in DONE
//     timeout_o      last run was aborted by the cycle limit
//     proto_err_o    sticky protocol violation, cleared by an accepted start
//     wr_count_o     LBP writes accepted this run, saturating at 2**ADDR_W
//     checksum_o     sum of accepted LBP codes, mod 2**16
// ----------------------------------------------------------------------------
module lbp_gray_host #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 8,
    parameter int DRAIN_CYC   = 2,
    parameter int TIMEOUT_CYC = 16777215
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              load_en_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              start_i,

    lbp_gray_if.slave         core_if,

    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,

    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic              proto_err_o,
    output logic [ADDR_W:0]   wr_count_o,
    output logic [15:0]       checksum_o
);

    localparam int DEPTH = 1 << ADDR_W;

    // Timer counts SERVE cycles 0 .. TIMEOUT_CYC-1; the drain counter counts
    // 0 .. DRAIN_CYC-1. Both keep at least one bit so degenerate settings
    // (limit 0 or 1) still elaborate.
    localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST =
        DRAIN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    localparam logic [ADDR_W:0] WR_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] WR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SERVE,
        S_DRAIN,
        S_DONE
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e              state_q,      state_d;
    logic [TIMER_W-1:0]  timer_q,      timer_d;
    logic [DRAIN_W-1:0]  drain_q,      drain_d;
    logic [ADDR_W:0]     wr_count_q,   wr_count_d;
    logic [15:0]         checksum_q,   checksum_d;
    logic                timeout_q,    timeout_d;
    logic                proto_err_q,  proto_err_d;
    logic                gray_ready_q;
    logic [DATA_W-1:0]   rd_data_q;

    logic [DATA_W-1:0]   gray_ram   [DEPTH];
    logic [DATA_W-1:0]   result_ram [DEPTH];

    // ------------------------------------------------------------------------
    // Qualified strobes
    // ------------------------------------------------------------------------
    logic in_serve;
    logic in_run;
    logic start_ok;
    logic load_we;
    logic lbp_we;
    logic violation;
    logic [DATA_W-1:0] gray_data_c;

    assign in_serve = (state_q == S_SERVE);
    assign in_run   = (state_q == S_SERVE) || (state_q == S_DRAIN);
    assign start_ok = start_i && !in_run;

    // Writes landing in the reset cycle belong to the aborted run and are
    // discarded along with it.
    assign load_we  = load_en_i         && !in_run && !reset;
    assign lbp_we   = core_if.lbp_valid &&  in_run && !reset;

    assign violation = (core_if.gray_req  && !in_serve) ||
                       (load_en_i         &&  in_run)   ||
                       (core_if.lbp_valid && !in_run);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every variable assigned here gets its default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        drain_d     = drain_q;
        wr_count_d  = wr_count_q;
        checksum_d  = checksum_q;
        timeout_d   = timeout_q;
        proto_err_d = proto_err_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d     = S_SERVE;
                    timer_d     = '0;
                    drain_d     = '0;
                    wr_count_d  = '0;
                    checksum_d  = '0;
                    timeout_d   = 1'b0;
                    proto_err_d = 1'b0;
                end
            end

            S_SERVE: begin
                timer_d = timer_q + TIMER_W'(1);
                // A finish arriving on the limit cycle still counts as a
                // normal completion.
                if (core_if.finish) begin
                    drain_d = '0;
                    state_d = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
                end else if ((TIMEOUT_CYC != 0) && (timer_q == TIMER_LAST)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end

            S_DRAIN: begin
                drain_d = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Result accounting. lbp_we is only possible in SERVE/DRAIN and
        // start_ok only outside them, so the run-clear above never collides.
        if (lbp_we) begin
            if (wr_count_q != WR_MAX) begin
                wr_count_d = wr_count_q + WR_ONE;
            end
            checksum_d = checksum_q + 16'(core_if.lbp_data);
        end

        // A violation in the same cycle as an accepted start is still kept.
        if (violation) begin
            proto_err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            drain_q      <= '0;
            wr_count_q   <= '0;
            checksum_q   <= '0;
            timeout_q    <= 1'b0;
            proto_err_q  <= 1'b0;
            gray_ready_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            drain_q      <= drain_d;
            wr_count_q   <= wr_count_d;
            checksum_q   <= checksum_d;
            timeout_q    <= timeout_d;
            proto_err_q  <= proto_err_d;
            // Registered copy of "next state is SERVE" so the flag tracks the
            // state register exactly without a decode on the output path.
            gray_ready_q <= (state_d == S_SERVE);
            rd_data_q    <= result_ram[rd_addr_i];
        end
    end

    // ------------------------------------------------------------------------
    // Memories
    // ------------------------------------------------------------------------
    // NOTE: the RAM arrays carry no reset; image and results survive a reset
    // and the arrays map onto plain block RAM.
    always_ff @(posedge clk) begin
        if (load_we) begin
            gray_ram[load_addr_i] <= load_data_i;
        end
        if (lbp_we) begin
            result_ram[core_if.lbp_addr] <= core_if.lbp_data;
        end
    end

    // Same-cycle read for the core; anything outside SERVE reads as zero so a
    // misbehaving core never sees stale image data.
    always_comb begin
        gray_data_c = '0;
        if (core_if.gray_req && in_serve) begin
            gray_data_c = gray_ram[core_if.gray_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign core_if.gray_ready = gray_ready_q;
    assign core_if.gray_data  = gray_data_c;

    assign rd_data_o   = rd_data_q;
    assign busy_o      = in_run;
    assign done_o      = (state_q == S_DONE);
    assign timeout_o   = timeout_q;
    assign proto_err_o = proto_err_q;
    assign wr_count_o  = wr_count_q;
    assign checksum_o  = checksum_q;

endmodule : lbp_gray_host
